// File: rtl/dmem_lsu.sv
// dmem_lsu: data-memory load/store unit with byte lanes, extension, wait states and error responses
module dmem_lsu #(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0]     wd,
  input  logic [2:0]            Funct3,
  output logic                  ready,
  output logic                  done,
  output logic                  err,
  output logic [DATA_W-1:0]     rd
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int IW = DM_ADDRESS - OW;
  localparam int LW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t r_state;
  logic [3:0] r_cnt;
  logic r_ready, r_done, r_err, r_mr, r_mw;
  logic [DATA_W-1:0] r_rd, r_wd;
  logic [DM_ADDRESS-1:0] r_a;
  logic [2:0] r_f3;
  logic [DATA_W-1:0] r_mem [2**IW];
  logic w_busy, w_mr, w_mw, w_acc, w_ill, w_mis, w_err, w_commit, w_we, w_sign;
  logic [DM_ADDRESS-1:0] w_a;
  logic [DATA_W-1:0] w_wd, w_word, w_sh, w_wsh, w_mask, w_ld, w_merged;
  logic [2:0] w_f3;
  logic [1:0] w_sz;
  logic [OW-1:0] w_off;
  logic [IW-1:0] w_idx;
  logic [LW-1:0] w_sidx;
  // While BUSY the access comes from the latched request, otherwise straight from the inputs
  assign w_busy = r_state == BUSY;
  assign w_a    = w_busy ? r_a : a;
  assign w_wd   = w_busy ? r_wd : wd;
  assign w_f3   = w_busy ? r_f3 : Funct3;
  assign w_mr   = w_busy ? r_mr : MemRead;
  assign w_mw   = w_busy ? r_mw : MemWrite;
  assign w_acc  = !w_busy && req && (MemRead || MemWrite);
  assign w_sz   = w_f3[1:0];
  assign w_off  = w_a[OW-1:0];
  assign w_idx  = w_a[DM_ADDRESS-1:OW];
  assign w_ill  = (w_mr && w_mw) || w_f3 == 3'b111 || (w_mw && w_f3[2]) ||
                  (DATA_W == 32 && (w_f3 == 3'b011 || w_f3 == 3'b110));
  assign w_mis  = (w_sz == 2'd1 && w_off[0]) || (w_sz == 2'd2 && w_off[1:0] != 2'b00) ||
                  (w_sz == 2'd3 && w_off != '0);
  assign w_err  = w_ill || w_mis;
  assign w_commit = w_busy ? r_cnt == 4'd0 : (w_acc && !w_err && WAIT_STATES == 0);
  assign w_we   = rst_n && w_commit && w_mw;
  assign w_word = r_mem[w_idx];
  assign w_sh   = w_word >> {w_off, 3'b000};
  assign w_mask = (DATA_W'(1) << (8 << w_sz)) - DATA_W'(1);
  assign w_sidx = LW'((8 << w_sz) - 1);
  assign w_sign = w_sh[w_sidx] && !w_f3[2];
  assign w_ld   = (w_sh & w_mask) | (w_sign ? ~w_mask : '0);
  assign w_wsh  = w_wd << {w_off, 3'b000};
  // Merge the shifted store data into the addressed lanes, keeping the others
  always_comb begin
    w_merged = w_word;
    for (int j = 0; j < NB; j++)
      w_merged[8*j +: 8] = (j >= int'(w_off) && j < int'(w_off) + (1 << w_sz)) ? w_wsh[8*j +: 8] : w_word[8*j +: 8];
  end
  // Array write port; contents are deliberately not reset
  always_ff @(posedge clk)
    if (w_we) r_mem[w_idx] <= w_merged;
  // Control FSM with registered handshake and response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= '0;
    end else if (w_busy) begin
      if (r_cnt == 4'd0) begin
        r_state <= RESP;
        r_ready <= 1'b1;
        r_done  <= 1'b1;
        if (r_mr) r_rd <= w_ld;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end else begin
      r_done <= w_acc && (w_err || WAIT_STATES == 0);
      r_err  <= w_acc && w_err;
      if (w_acc) begin
        r_a  <= a;
        r_wd <= wd;
        r_f3 <= Funct3;
        r_mr <= MemRead;
        r_mw <= MemWrite;
      end
      if (!w_acc) begin
        r_state <= IDLE;
      end else if (w_err) begin
        r_state <= RESP;
        r_rd    <= '0;
      end else if (WAIT_STATES == 0) begin
        r_state <= RESP;
        if (MemRead) r_rd <= w_ld;
      end else begin
        r_state <= BUSY;
        r_ready <= 1'b0;
        r_cnt   <= 4'(WAIT_STATES - 1);
      end
    end
  end
  assign ready = r_ready;
  assign done  = r_done;
  assign err   = r_err;
  assign rd    = r_rd;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: randomized scoreboard bench over three configurations of dmem_lsu
module tb_dmem_lsu;
  typedef struct {
    int          cyc;
    logic [63:0] rd;
    logic        err;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic rst_n [3];
  logic req [3];
  logic mr [3];
  logic mw [3];
  logic [8:0] ad [3];
  logic [63:0] wdv [3];
  logic [2:0] f3 [3];
  logic rdy [3];
  logic don [3];
  logic er [3];
  logic [31:0] rd0, rd1;
  logic [63:0] rd2;
  exp_t q0[$], q1[$], q2[$];
  logic [7:0] mm [3][512];
  logic [63:0] last_rd [3];
  int last_acc [3];
  int nchk = 0;
  int nerr = 0;
  dmem_lsu #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .MemRead(mr[0]), .MemWrite(mw[0]), .a(ad[0]),
    .wd(wdv[0][31:0]), .Funct3(f3[0]), .ready(rdy[0]), .done(don[0]), .err(er[0]), .rd(rd0));
  dmem_lsu #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_STATES(3)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .MemRead(mr[1]), .MemWrite(mw[1]), .a(ad[1]),
    .wd(wdv[1][31:0]), .Funct3(f3[1]), .ready(rdy[1]), .done(don[1]), .err(er[1]), .rd(rd1));
  dmem_lsu #(.DM_ADDRESS(9), .DATA_W(64), .WAIT_STATES(1)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .req(req[2]), .MemRead(mr[2]), .MemWrite(mw[2]), .a(ad[2]),
    .wd(wdv[2]), .Funct3(f3[2]), .ready(rdy[2]), .done(don[2]), .err(er[2]), .rd(rd2));
  function automatic int ws(int k);
    return k == 1 ? 3 : k == 2 ? 1 : 0;
  endfunction
  function automatic int dw(int k);
    return k == 2 ? 64 : 32;
  endfunction
  function automatic logic [63:0] getrd(int k);
    return k == 0 ? {32'h0, rd0} : k == 1 ? {32'h0, rd1} : rd2;
  endfunction
  task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] want);
    nchk++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s dut%0d: got %h want %h", nm, k, act, want);
    end
  endtask
  // Reference model: byte-addressed memory, alignment by access size, little-endian assembly
  task automatic model(int k, bit r, bit w, logic [8:0] adr, logic [63:0] d, logic [2:0] f,
                       output logic e, output logic [63:0] v);
    int n = 1 << f[1:0];
    int b = dw(k);
    e = (r && w) || f == 3'd7 || (w && f[2]) || (b == 32 && (f == 3'd3 || f == 3'd6)) ||
        (int'(adr) % n != 0);
    v = '0;
    if (e) return;
    for (int i = 0; i < n; i++)
      if (w) mm[k][int'(adr) + i] = d[8*i +: 8];
      else v[8*i +: 8] = mm[k][int'(adr) + i];
    if (r && !f[2])
      for (int i = 8 * n; i < 64; i++) v[i] = v[8*n-1];
    if (b == 32) v[63:32] = '0;
  endtask
  // Drive one request at a negedge where ready is high; push the expected response
  task automatic issue(int k, bit r, bit w, logic [8:0] adr, logic [63:0] d, logic [2:0] f,
                       bit use_w = 0, logic [63:0] want = 0, bit track = 1);
    exp_t x;
    int n = 0;
    logic e;
    logic [63:0] v;
    while (rdy[k] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rdy[k] !== 1'b1) begin
      chk("ready_timeout", k, 64'd0, 64'd1);
      return;
    end
    req[k] = 1'b1;
    mr[k] = r;
    mw[k] = w;
    ad[k] = adr;
    wdv[k] = d;
    f3[k] = f;
    last_acc[k] = cyc + 1;
    if (track) begin
      model(k, r, w, adr, d, f, e, v);
      x.err = e;
      x.rd = e ? 64'd0 : r ? (use_w ? want : v) : last_rd[k];
      last_rd[k] = x.rd;
      x.cyc = cyc + 1 + (e ? 0 : ws(k));
      if (k == 0) q0.push_back(x);
      else if (k == 1) q1.push_back(x);
      else q2.push_back(x);
    end
    @(negedge clk);
    req[k] = 1'b0;
    mr[k] = 1'($urandom);
    mw[k] = 1'($urandom);
    ad[k] = 9'($urandom);
    wdv[k] = {$urandom, $urandom};
    f3[k] = 3'($urandom);
  endtask
  // Monitor: every done pops the oldest expectation of that instance
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_n[k] === 1'b1 && don[k] === 1'b1) begin
        exp_t x;
        int n;
        n = k == 0 ? q0.size() : k == 1 ? q1.size() : q2.size();
        if (n == 0) begin
          chk("unexpected_done", k, 64'd1, 64'd0);
        end else begin
          if (k == 0) x = q0.pop_front();
          else if (k == 1) x = q1.pop_front();
          else x = q2.pop_front();
          chk("err", k, 64'(er[k]), 64'(x.err));
          chk("rd", k, getrd(k), x.rd);
          chk("latency", k, 64'(cyc), 64'(x.cyc));
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int prev;
    bit r, w;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0;
      req[k] = 1'b0;
      mr[k] = 1'b0;
      mw[k] = 1'b0;
      ad[k] = '0;
      wdv[k] = '0;
      f3[k] = '0;
      last_rd[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", k, 64'(rdy[k]), 64'd1);
      chk("rst_done", k, 64'(don[k]), 64'd0);
      chk("rst_err", k, 64'(er[k]), 64'd0);
      chk("rst_rd", k, getrd(k), 64'd0);
      rst_n[k] = 1'b1;
    end
    @(negedge clk);
    issue(0, 0, 1, 9'h10, 64'h8000_80F1, 3'd2);
    issue(0, 1, 0, 9'h10, 0, 3'd0, 1, 64'hFFFF_FFF1);
    issue(0, 1, 0, 9'h10, 0, 3'd4, 1, 64'h0000_00F1);
    issue(0, 1, 0, 9'h12, 0, 3'd1, 1, 64'hFFFF_8000);
    issue(0, 1, 0, 9'h12, 0, 3'd5, 1, 64'h0000_8000);
    issue(0, 0, 1, 9'h20, 64'h1122_3344, 3'd2);
    issue(0, 0, 1, 9'h23, 64'hAB, 3'd0);
    issue(0, 0, 1, 9'h20, 64'hCDEF, 3'd1);
    issue(0, 1, 0, 9'h20, 0, 3'd2, 1, 64'hAB22_CDEF);
    issue(0, 1, 0, 9'h11, 0, 3'd1);
    issue(0, 0, 1, 9'h22, 64'hDEAD_BEEF, 3'd2);
    issue(0, 1, 0, 9'h20, 0, 3'd2, 1, 64'hAB22_CDEF);
    issue(0, 1, 1, 9'h20, 64'h1, 3'd2);
    issue(1, 0, 1, 9'h40, 64'hA5A5_0F0F, 3'd2);
    chk("ready_busy", 1, 64'(rdy[1]), 64'd0);
    prev = last_acc[1];
    issue(1, 1, 0, 9'h40, 0, 3'd2, 1, 64'hA5A5_0F0F);
    chk("accept_gap", 1, 64'(last_acc[1] - prev), 64'd4);
    prev = last_acc[1];
    issue(1, 0, 1, 9'h42, 64'h3C, 3'd0);
    chk("accept_gap", 1, 64'(last_acc[1] - prev), 64'd4);
    prev = last_acc[1];
    issue(1, 1, 0, 9'h42, 0, 3'd5, 1, 64'h0000_A53C);
    chk("accept_gap", 1, 64'(last_acc[1] - prev), 64'd4);
    issue(1, 0, 1, 9'h30, 64'h0, 3'd2);
    issue(1, 0, 1, 9'h34, 64'h1234_5678, 3'd2);
    issue(1, 1, 0, 9'h34, 0, 3'd2, 1, 64'h1234_5678);
    issue(1, 0, 1, 9'h30, 64'h5555_5555, 3'd2, 0, 0, 0);
    @(negedge clk);
    rst_n[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    last_rd[1] = '0;
    chk("abort_ready", 1, 64'(rdy[1]), 64'd1);
    chk("abort_done", 1, 64'(don[1]), 64'd0);
    chk("abort_err", 1, 64'(er[1]), 64'd0);
    chk("abort_rd", 1, getrd(1), 64'd0);
    issue(1, 1, 0, 9'h30, 0, 3'd2, 1, 64'h0);
    issue(2, 0, 1, 9'h08, 64'h8877_6655_4433_2211, 3'd3);
    issue(2, 1, 0, 9'h0C, 0, 3'd2, 1, 64'hFFFF_FFFF_8877_6655);
    issue(2, 1, 0, 9'h0C, 0, 3'd6, 1, 64'h0000_0000_8877_6655);
    issue(2, 1, 0, 9'h08, 0, 3'd3, 1, 64'h8877_6655_4433_2211);
    issue(2, 1, 0, 9'h0C, 0, 3'd3);
    for (int k = 0; k < 3; k++) begin
      for (int ad_i = 'h40; ad_i < 'h80; ad_i += dw(k) / 8)
        issue(k, 0, 1, 9'(ad_i), {$urandom, $urandom}, dw(k) == 64 ? 3'd3 : 3'd2);
      for (int i = 0; i < 60; i++) begin
        r = 1'($urandom);
        w = !r;
        if ($urandom_range(0, 9) == 0) begin
          r = 1'b1;
          w = 1'b1;
        end
        issue(k, r, w, 9'h40 + 9'($urandom_range(0, 63)), {$urandom, $urandom}, 3'($urandom));
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    repeat (10) @(negedge clk);
    chk("queue_empty", 0, 64'(q0.size()), 64'd0);
    chk("queue_empty", 1, 64'(q1.size()), 64'd0);
    chk("queue_empty", 2, 64'(q2.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
